dm_wait: RTL

- Parametrised successor to the single-cycle data memory.
- Word-organised data RAM with a valid/ready request port, configurable access latency (wait states), byte/half/word loads (sign- or zero-extended) and stores, and alignment/range exception reporting.
- Sits behind the MEM stage. The pipeline stalls while `req_ready` is low or a response is pending. This is the memory model for multi-cycle-memory and exception-capable CPU generations.

---
 rtl/dm_wait.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dm_wait.sv
// Word-organised data RAM behind a valid/ready port with LATENCY wait states,
// sub-word loads/stores and alignment/range exception reporting.
module dm_wait #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    input  logic        req_we,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc
);

    localparam int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_LOAD    = 4'(LATENCY - 1);

    localparam logic [2:0] SZ_WORD  = 3'd0;
    localparam logic [2:0] SZ_BYTE  = 3'd1;
    localparam logic [2:0] SZ_HALF  = 3'd2;
    localparam logic [2:0] SZ_BYTEU = 3'd3;
    localparam logic [2:0] SZ_HALFU = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic        we_q;
    logic [31:0] rdata_q;
    logic [1:0]  exc_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic          accept, access, exc_hit;
    logic [31:0]   offset, cur_word, load_data, wr_word;
    logic [AW-1:0] idx;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign resp_valid = (state_q == S_RESP) && !reset;
    assign resp_rdata = rdata_q;
    assign resp_exc   = exc_q;

    assign accept   = req_valid && req_ready;
    assign access   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign offset   = addr_q - BASE_ADDR;
    assign idx      = offset[AW+1:2];
    assign cur_word = mem_q[idx];
    assign byte_sel = 8'(cur_word >> {addr_q[1:0], 3'b000});
    assign half_sel = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Priority order matters: size legality is judged before alignment and range.
    always_comb begin
        exc_hit = 1'b0;
        if (size_q > SZ_HALFU)
            exc_hit = 1'b1;
        else if (we_q && (size_q == SZ_BYTEU || size_q == SZ_HALFU))
            exc_hit = 1'b1;
        else if ((size_q == SZ_HALF || size_q == SZ_HALFU) && addr_q[0])
            exc_hit = 1'b1;
        else if (size_q == SZ_WORD && addr_q[1:0] != 2'b00)
            exc_hit = 1'b1;
        else if (offset >= RANGE_BYTES)
            exc_hit = 1'b1;
    end

    always_comb begin
        load_data = '0;
        unique case (size_q)
            SZ_WORD:  load_data = cur_word;
            SZ_BYTE:  load_data = {{24{byte_sel[7]}}, byte_sel};
            SZ_BYTEU: load_data = {24'd0, byte_sel};
            SZ_HALF:  load_data = {{16{half_sel[15]}}, half_sel};
            SZ_HALFU: load_data = {16'd0, half_sel};
            default:  load_data = '0;
        endcase
    end

    always_comb begin
        wr_word = cur_word;
        unique case (size_q)
            SZ_WORD: wr_word = wdata_q;
            SZ_BYTE: wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wr_word = cur_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            exc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                size_q  <= req_size;
                we_q    <= req_we;
            end
            if (access) begin
                if (exc_hit) begin
                    rdata_q <= '0;
                    exc_q   <= we_q ? 2'd2 : 2'd1;
                end else begin
                    rdata_q <= we_q ? 32'd0 : load_data;
                    exc_q   <= 2'd0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
        end else if (access && we_q && !exc_hit) begin
            mem_q[idx] <= wr_word;
        end
    end

endmodule
